// File: rtl/screen_scanout.sv
// screen_scanout: fetches the 64x32 CHIP-8 framebuffer byte-by-byte over the shared memory port
// and streams its pixels in raster order over valid/ready. Build macro SCANOUT_INVERT_EN inverts pixel.
module screen_scanout #(
  parameter logic [15:0] screen_start = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_read_byte,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        pixel,
  output logic [5:0]  pixel_x,
  output logic [4:0]  pixel_y
);

`ifdef SCANOUT_INVERT_EN
  localparam logic invert = 1'b1;
`else
  localparam logic invert = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, FETCH, SHIFT} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] byte_index;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       accept;
  logic       last_bit;
  logic       last_byte;

  assign accept    = pixel_valid && pixel_ready;
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_index == 8'hFF);

  // Eight bytes per row, MSB is the leftmost pixel, so the coordinates fall straight out of the counters.
  assign pixel_x = {byte_index[2:0], bit_cnt};
  assign pixel_y = byte_index[7:3];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: defaulting state_next first covers every path, so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (mem_grant) state_next = FETCH;
      FETCH:   state_next = SHIFT;
      SHIFT:   if (accept && last_bit) state_next = last_byte ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= 16'h0000;
      pixel_valid <= 1'b0;
      pixel       <= 1'b0;
      byte_index  <= 8'h00;
      shift_reg   <= 8'h00;
      bit_cnt     <= 3'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            byte_index <= 8'h00;
            bit_cnt    <= 3'd0;
            mem_addr   <= screen_start;
            mem_read   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          // Read data is valid the cycle after the granted request, which is this one.
          shift_reg   <= mem_read_byte;
          mem_read    <= 1'b0;
          pixel_valid <= 1'b1;
          pixel       <= mem_read_byte[7] ^ invert;
          bit_cnt     <= 3'd0;
        end
        SHIFT: begin
          if (accept) begin
            if (!last_bit) begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              pixel     <= shift_reg[6] ^ invert;
              bit_cnt   <= bit_cnt + 3'd1;
            end else if (!last_byte) begin
              pixel_valid <= 1'b0;
              byte_index  <= byte_index + 8'd1;
              mem_addr    <= screen_start + {8'h00, byte_index} + 16'd1;
              mem_read    <= 1'b1;
            end else begin
              pixel_valid <= 1'b0;
              frame_done  <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench for screen_scanout: memory model behind the grant, pixel stream checked against
// the framebuffer contents, plus grant stalls, ready backpressure, ignored starts and mid-frame reset.
module tb_screen_scanout;

`ifdef SCANOUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic        mem_grant;
  logic [7:0]  mem_read_byte;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel;
  logic [5:0]  pixel_x;
  logic [4:0]  pixel_y;

  screen_scanout dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_grant    (mem_grant),
    .mem_read_byte(mem_read_byte),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel        (pixel),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y)
  );

  always #5 clk = ~clk;

  logic [7:0] fb [256];
  logic       cap [2048];

  // Shared memory port: data for a granted read appears the following cycle.
  always @(posedge clk) begin
    logic [15:0] off;
    off = mem_addr - 16'h0100;
    if (mem_read && mem_grant) mem_read_byte <= (off < 16'd256) ? fb[off[7:0]] : 8'hFF;
  end

  int n_checks = 0;
  int n_fails  = 0;
  int n_acc, n_err, n_hold, n_done, done_cycle, first_valid;
  bit aborted;
  logic busy_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, ".busy"},        32'(busy),        32'd0);
    check({where, ".frame_done"},  32'(frame_done),  32'd0);
    check({where, ".mem_read"},    32'(mem_read),    32'd0);
    check({where, ".mem_addr"},    32'(mem_addr),    32'd0);
    check({where, ".pixel_valid"}, 32'(pixel_valid), 32'd0);
    check({where, ".pixel"},       32'(pixel),       32'd0);
    check({where, ".pixel_x"},     32'(pixel_x),     32'd0);
    check({where, ".pixel_y"},     32'(pixel_y),     32'd0);
  endtask

  // One frame: start pulse, then every negedge observes outputs and drives grant/ready/start for the next edge.
  task automatic run_frame(input bit rand_ready, input int grant_delay, input int start_at, input int abort_at);
    int c;
    int idx;
    bit stall;
    logic [5:0] sx;
    logic [4:0] sy;
    logic sp;
    logic [7:0] b;
    logic exp_p;
    n_acc = 0; n_err = 0; n_hold = 0; n_done = 0; done_cycle = -1; first_valid = -1;
    aborted = 1'b0; busy_at_done = 1'bx; stall = 1'b0;
    sx = '0; sy = '0; sp = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mem_grant = (grant_delay == 0);
    pixel_ready = 1'b1;
    c = 0;
    while (c < 8000 && n_done == 0) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      start = 1'b0;
      if (frame_done) begin
        n_done++;
        done_cycle = c;
        busy_at_done = busy;
      end
      if (c <= grant_delay && !(mem_read && mem_addr == 16'h0100 && !pixel_valid)) n_hold++;
      mem_grant = (c > grant_delay);
      if (stall && !(pixel_valid && pixel_x == sx && pixel_y == sy && pixel == sp)) n_err++;
      if (abort_at >= 0 && pixel_valid && n_acc == abort_at) begin
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (pixel_valid && first_valid < 0) first_valid = c;
      pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pixel_valid && pixel_ready) begin
        idx = n_acc;
        if (idx < 2048) begin
          b = fb[idx / 8];
          exp_p = b[7 - (idx % 8)] ^ INV;
          if (pixel_x != 6'(idx % 64) || pixel_y != 5'(idx / 64) || pixel !== exp_p) n_err++;
          cap[idx] = pixel;
        end else begin
          n_err++;
        end
        if (start_at == idx) start = 1'b1;
        n_acc++;
      end
      stall = pixel_valid && !pixel_ready;
      sx = pixel_x; sy = pixel_y; sp = pixel;
    end
    if (aborted) return;
    pixel_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_done) n_done++;
      if (busy || mem_read || pixel_valid) n_err++;
    end
  endtask

  initial begin
    logic [7:0] pat;
    int quiet;
    reset = 1'b1; start = 1'b0; mem_grant = 1'b1; pixel_ready = 1'b1;
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    fb[0]   = 8'hA5;
    fb[255] = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Sparse framebuffer, grant and ready held high.
    run_frame(1'b0, 0, -1, -1);
    check("f1.accepts", 32'(n_acc), 32'd2048);
    check("f1.stream_errors", 32'(n_err), 32'd0);
    check("f1.done_pulses", 32'(n_done), 32'd1);
    check("f1.done_cycle", 32'(done_cycle), 32'd2561);
    check("f1.first_valid_cycle", 32'(first_valid), 32'd3);
    check("f1.busy_at_done", 32'(busy_at_done), 32'd0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) check($sformatf("f1.pixel%0d", i), 32'(cap[i]), 32'(pat[7 - i] ^ INV));
    check("f1.last_pixel", 32'(cap[2047]), 32'(1'b1 ^ INV));

    // Grant withheld for the first 20 REQ cycles.
    run_frame(1'b0, 20, -1, -1);
    check("grant.hold_errors", 32'(n_hold), 32'd0);
    check("grant.stream_errors", 32'(n_err), 32'd0);
    check("grant.accepts", 32'(n_acc), 32'd2048);
    check("grant.done_cycle", 32'(done_cycle), 32'd2581);

    for (int i = 0; i < 256; i++) fb[i] = 8'(i * 29 + 7);

    // Random backpressure on a dense framebuffer.
    run_frame(1'b1, 0, -1, -1);
    check("ready.accepts", 32'(n_acc), 32'd2048);
    check("ready.stream_errors", 32'(n_err), 32'd0);
    check("ready.done_pulses", 32'(n_done), 32'd1);

    // Second start mid-frame must not disturb the scan or queue a new one.
    run_frame(1'b0, 0, 500, -1);
    check("midstart.accepts", 32'(n_acc), 32'd2048);
    check("midstart.stream_errors", 32'(n_err), 32'd0);
    check("midstart.done_pulses", 32'(n_done), 32'd1);
    check("midstart.done_cycle", 32'(done_cycle), 32'd2561);

    // Start coinciding with the final accept is also ignored.
    run_frame(1'b0, 0, 2047, -1);
    check("endstart.accepts", 32'(n_acc), 32'd2048);
    check("endstart.stream_errors", 32'(n_err), 32'd0);
    check("endstart.done_pulses", 32'(n_done), 32'd1);

    // Reset while pixel (10,3) is on the bus.
    run_frame(1'b0, 0, -1, 3 * 64 + 10);
    check("abort.reached", 32'(aborted), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy || frame_done || pixel_valid || mem_read) quiet++;
    end
    check("abort.quiet_after", 32'(quiet), 32'd0);
    run_frame(1'b0, 0, -1, -1);
    check("rescan.accepts", 32'(n_acc), 32'd2048);
    check("rescan.stream_errors", 32'(n_err), 32'd0);
    check("rescan.done_cycle", 32'(done_cycle), 32'd2561);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
